// File: rtl/rom_arbiter_pkg.sv
// Shared widths, access-size codes and port identifiers for the ROM arbiter slice.
// Stands in for the femto.vh bus macros so every file sees one definition.
package rom_arbiter_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int ROM_SIZE      = 1024;
  localparam int ROM_AW        = $clog2(ROM_SIZE);

  typedef logic [BUS_WIDTH-1:0]     bus_word_t;
  typedef logic [BUS_ACC_WIDTH-1:0] bus_acc_t;

  localparam bus_acc_t BUS_ACC_1B = 2'd0;
  localparam bus_acc_t BUS_ACC_2B = 2'd1;
  localparam bus_acc_t BUS_ACC_4B = 2'd2;

  localparam logic ROM_ARB_PORT_I = 1'b0;
  localparam logic ROM_ARB_PORT_D = 1'b1;

endpackage

// File: rtl/rom_arbiter_if.sv
// femto bus: request fields flow master->slave, completion flows slave->master.
interface rom_arbiter_if
  import rom_arbiter_pkg::*;
#(
  parameter int AW = ROM_AW
);

  logic [AW-1:0] addr;
  logic          w_rb;
  bus_acc_t      acc;
  bus_word_t     wdata;
  logic          req;
  bus_word_t     rdata;
  logic          resp;
  logic          fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );

endinterface

// File: rtl/rom_arb_pending.sv
// Single-entry holding buffer for a request that lost arbitration.
// Only the valid flag is reset; the fields are meaningful only while valid.
module rom_arb_pending
  import rom_arbiter_pkg::*;
#(
  parameter int AW = ROM_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          capture,
  input  logic          clear,
  input  logic [AW-1:0] addr,
  input  logic          w_rb,
  input  bus_acc_t      acc,
  input  bus_word_t     wdata,
  output logic          valid,
  output logic [AW-1:0] buf_addr,
  output logic          buf_w_rb,
  output bus_acc_t      buf_acc,
  output bus_word_t     buf_wdata
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_addr  <= addr;
      buf_w_rb  <= w_rb;
      buf_acc   <= acc;
      buf_wdata <= wdata;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one ROM controller between the I-fetch and data buses.
// Grants combinationally, buffers one loser per port, routes resp via an owner register.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int AW = ROM_AW
) (
  input  logic         clk,
  input  logic         rstn,
  rom_arbiter_if.slave  i_bus,
  rom_arbiter_if.slave  d_bus,
  rom_arbiter_if.master rom_bus
);

  logic          pi_v, pd_v;
  logic [AW-1:0] pi_addr, pd_addr;
  logic          pi_w_rb, pd_w_rb;
  bus_acc_t      pi_acc, pd_acc;
  bus_word_t     pi_wdata, pd_wdata;

  logic [AW-1:0] ci_addr, cd_addr;
  logic          ci_w_rb, cd_w_rb;
  bus_acc_t      ci_acc, cd_acc;
  bus_word_t     ci_wdata, cd_wdata;

  logic cand_i, cand_d;
  logic grant_i, grant_d, grant_any;
  logic last_grant;
  logic owner_v, owner_id;

  rom_arb_pending #(.AW(AW)) u_pend_i (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (i_bus.req & ~pi_v & ~grant_i),
    .clear     (pi_v & grant_i),
    .addr      (i_bus.addr),
    .w_rb      (i_bus.w_rb),
    .acc       (i_bus.acc),
    .wdata     (i_bus.wdata),
    .valid     (pi_v),
    .buf_addr  (pi_addr),
    .buf_w_rb  (pi_w_rb),
    .buf_acc   (pi_acc),
    .buf_wdata (pi_wdata)
  );

  rom_arb_pending #(.AW(AW)) u_pend_d (
    .clk       (clk),
    .rstn      (rstn),
    .capture   (d_bus.req & ~pd_v & ~grant_d),
    .clear     (pd_v & grant_d),
    .addr      (d_bus.addr),
    .w_rb      (d_bus.w_rb),
    .acc       (d_bus.acc),
    .wdata     (d_bus.wdata),
    .valid     (pd_v),
    .buf_addr  (pd_addr),
    .buf_w_rb  (pd_w_rb),
    .buf_acc   (pd_acc),
    .buf_wdata (pd_wdata)
  );

  // A buffered entry shadows the live bus: a new req on a busy port is dropped.
  always_comb begin
    ci_addr  = pi_v ? pi_addr  : i_bus.addr;
    ci_w_rb  = pi_v ? pi_w_rb  : i_bus.w_rb;
    ci_acc   = pi_v ? pi_acc   : i_bus.acc;
    ci_wdata = pi_v ? pi_wdata : i_bus.wdata;
    cd_addr  = pd_v ? pd_addr  : d_bus.addr;
    cd_w_rb  = pd_v ? pd_w_rb  : d_bus.w_rb;
    cd_acc   = pd_v ? pd_acc   : d_bus.acc;
    cd_wdata = pd_v ? pd_wdata : d_bus.wdata;
  end

  assign cand_i    = pi_v | i_bus.req;
  assign cand_d    = pd_v | d_bus.req;
  assign grant_i   = cand_i & (~cand_d | (last_grant == ROM_ARB_PORT_D));
  assign grant_d   = cand_d & ~grant_i;
  assign grant_any = grant_i | grant_d;

  always_comb begin
    rom_bus.req   = rstn & grant_any;
    rom_bus.addr  = '0;
    rom_bus.w_rb  = 1'b0;
    rom_bus.acc   = '0;
    rom_bus.wdata = '0;
    if (grant_i) begin
      rom_bus.addr  = ci_addr;
      rom_bus.w_rb  = ci_w_rb;
      rom_bus.acc   = ci_acc;
      rom_bus.wdata = ci_wdata;
    end else if (grant_d) begin
      rom_bus.addr  = cd_addr;
      rom_bus.w_rb  = cd_w_rb;
      rom_bus.acc   = cd_acc;
      rom_bus.wdata = cd_wdata;
    end
  end

  // Owner tracks the one access in flight; a faulted grant never gets a resp.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner_v    <= 1'b0;
      last_grant <= ROM_ARB_PORT_D;
    end else begin
      owner_v <= rom_bus.req & ~rom_bus.fault;
      if (grant_any) begin
        last_grant <= grant_d ? ROM_ARB_PORT_D : ROM_ARB_PORT_I;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any) begin
      owner_id <= grant_d ? ROM_ARB_PORT_D : ROM_ARB_PORT_I;
    end
  end

  assign i_bus.fault = rstn & rom_bus.fault & grant_i;
  assign d_bus.fault = rstn & rom_bus.fault & grant_d;
  assign i_bus.resp  = rstn & rom_bus.resp & owner_v & (owner_id == ROM_ARB_PORT_I);
  assign d_bus.resp  = rstn & rom_bus.resp & owner_v & (owner_id == ROM_ARB_PORT_D);
  assign i_bus.rdata = rom_bus.rdata;
  assign d_bus.rdata = rom_bus.rdata;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: ROM controller model plus a transaction-level arbitration model.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int AW = ROM_AW;

  logic clk;
  logic rstn;
  logic spurious;
  int   total, bad;

  rom_arbiter_if #(.AW(AW)) i_bus ();
  rom_arbiter_if #(.AW(AW)) d_bus ();
  rom_arbiter_if #(.AW(AW)) rom_bus ();

  rom_arbiter #(.AW(AW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_bus   (i_bus),
    .d_bus   (d_bus),
    .rom_bus (rom_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_word_t mem [ROM_SIZE/4];

  function automatic bit misal(input logic [AW-1:0] a, input bus_acc_t acc);
    return (acc == BUS_ACC_2B && a[0]) || (acc == BUS_ACC_4B && a[1:0] != 2'b00);
  endfunction

  // ROM controller: combinational reject, one-cycle read latency.
  assign rom_bus.fault = rom_bus.req & (rom_bus.w_rb | misal(rom_bus.addr, rom_bus.acc));
  always @(posedge clk) begin
    rom_bus.resp  <= rom_bus.req & (~rom_bus.fault | spurious);
    rom_bus.rdata <= mem[rom_bus.addr[AW-1:2]];
  end

  // Reference model: one outstanding request slot per port (0 = I, 1 = D).
  bit            mv    [2];
  bit            outst [2];
  logic [AW-1:0] m_addr[2];
  bit            m_w   [2];
  bus_acc_t      m_acc [2];
  bus_word_t     m_wd  [2];
  int            mlast;
  int            presp;
  bus_word_t     prdata;
  int            issued[2];
  int            done  [2];
  int            d_req_cyc, d_done_cyc;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mv[p] = 0; outst[p] = 0;
    end
    mlast = 1;
    presp = -1;
  endtask

  task automatic drive_port(input int p, input bit req, input logic [AW-1:0] a,
                            input bit w, input bus_acc_t acc, input bus_word_t wd);
    if (p == 0) begin
      i_bus.req = req; i_bus.addr = a; i_bus.w_rb = w; i_bus.acc = acc; i_bus.wdata = wd;
    end else begin
      d_bus.req = req; d_bus.addr = a; d_bus.w_rb = w; d_bus.acc = acc; d_bus.wdata = wd;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    i_bus.req = 1'b0;
    d_bus.req = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    spurious = 1'b0;
    drive_port(0, 0, '0, 0, '0, '0);
    drive_port(1, 0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_port(0, 1, 'h010, 0, BUS_ACC_4B, '0);
    drive_port(1, 1, 'h004, 0, BUS_ACC_4B, '0);
    @(negedge clk);
    total++;
    if ({rom_bus.req, i_bus.resp, d_bus.resp, i_bus.fault, d_bus.fault} !== 5'b0) begin
      bad++;
      $display("FAIL reset_first_cycle: got %b expected 00000",
               {rom_bus.req, i_bus.resp, d_bus.resp, i_bus.fault, d_bus.fault});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (rom_bus.req !== 1'b0) begin
      bad++;
      $display("FAIL reset_req_held: got %b expected 0", rom_bus.req);
    end
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({rom_bus.req, i_bus.resp, d_bus.resp} !== 3'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got %b expected 000", {rom_bus.req, i_bus.resp, d_bus.resp});
    end
    next_cycle();
    model_reset();
  endtask

  task automatic test_uncontended();
    do_reset();
    drive_port(0, 1, 'h010, 0, BUS_ACC_4B, '0);
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr, rom_bus.acc} !== {1'b1, AW'('h010), BUS_ACC_4B}) begin
      bad++;
      $display("FAIL unc_grant: got %h expected %h", {rom_bus.req, rom_bus.addr, rom_bus.acc},
               {1'b1, AW'('h010), BUS_ACC_4B});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp, i_bus.rdata} !== {2'b10, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL unc_resp: got %h expected %h", {i_bus.resp, d_bus.resp, i_bus.rdata},
               {2'b10, 32'hDEADBEEF});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp} !== 2'b00) begin
      bad++;
      $display("FAIL unc_resp_pulse: got %b expected 00", {i_bus.resp, d_bus.resp});
    end
  endtask

  task automatic test_contended();
    do_reset();
    drive_port(0, 1, 'h000, 0, BUS_ACC_4B, '0);
    drive_port(1, 1, 'h004, 0, BUS_ACC_4B, '0);
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr} !== {1'b1, AW'('h000)}) begin
      bad++;
      $display("FAIL cont_i_first: got %h expected %h", {rom_bus.req, rom_bus.addr}, {1'b1, AW'('h000)});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr, i_bus.resp, d_bus.resp, i_bus.rdata} !==
        {1'b1, AW'('h004), 2'b10, mem[0]}) begin
      bad++;
      $display("FAIL cont_d_second: got %h expected %h",
               {rom_bus.req, rom_bus.addr, i_bus.resp, d_bus.resp, i_bus.rdata},
               {1'b1, AW'('h004), 2'b10, mem[0]});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({rom_bus.req, i_bus.resp, d_bus.resp, d_bus.rdata} !== {3'b001, mem[1]}) begin
      bad++;
      $display("FAIL cont_d_resp: got %h expected %h",
               {rom_bus.req, i_bus.resp, d_bus.resp, d_bus.rdata}, {3'b001, mem[1]});
    end
    next_cycle();
  endtask

  task automatic test_write_fault();
    do_reset();
    spurious = 1'b1;
    drive_port(1, 1, 'h008, 1, BUS_ACC_4B, 32'h12345678);
    @(negedge clk);
    total++;
    if ({rom_bus.req, d_bus.fault, i_bus.fault} !== 3'b110) begin
      bad++;
      $display("FAIL wr_fault: got %b expected 110", {rom_bus.req, d_bus.fault, i_bus.fault});
    end
    next_cycle();
    spurious = 1'b0;
    drive_port(0, 1, 'h010, 0, BUS_ACC_4B, '0);
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp, rom_bus.req, rom_bus.addr} !== {3'b001, AW'('h010)}) begin
      bad++;
      $display("FAIL wr_no_resp: got %h expected %h", {i_bus.resp, d_bus.resp, rom_bus.req, rom_bus.addr},
               {3'b001, AW'('h010)});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp, d_bus.fault, i_bus.rdata} !== {3'b100, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL wr_next_i: got %h expected %h", {i_bus.resp, d_bus.resp, d_bus.fault, i_bus.rdata},
               {3'b100, 32'hDEADBEEF});
    end
    next_cycle();
  endtask

  task automatic test_misaligned();
    do_reset();
    drive_port(0, 1, 'h010, 0, BUS_ACC_4B, '0);
    next_cycle();
    next_cycle();
    drive_port(0, 1, 'h00C, 0, BUS_ACC_4B, '0);
    drive_port(1, 1, 'h003, 0, BUS_ACC_2B, '0);
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr, i_bus.fault, d_bus.fault} !== {1'b1, AW'('h003), 2'b01}) begin
      bad++;
      $display("FAIL mis_fault_d: got %h expected %h", {rom_bus.req, rom_bus.addr, i_bus.fault, d_bus.fault},
               {1'b1, AW'('h003), 2'b01});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr, i_bus.fault, d_bus.fault, i_bus.resp, d_bus.resp} !==
        {1'b1, AW'('h00C), 4'b0000}) begin
      bad++;
      $display("FAIL mis_i_grant: got %h expected %h",
               {rom_bus.req, rom_bus.addr, i_bus.fault, d_bus.fault, i_bus.resp, d_bus.resp},
               {1'b1, AW'('h00C), 4'b0000});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp, i_bus.rdata} !== {2'b10, mem[3]}) begin
      bad++;
      $display("FAIL mis_i_resp: got %h expected %h", {i_bus.resp, d_bus.resp, i_bus.rdata}, {2'b10, mem[3]});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_port(0, 1, 'h010, 0, BUS_ACC_4B, '0);
    drive_port(1, 1, 'h004, 0, BUS_ACC_4B, '0);
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr} !== {1'b1, AW'('h010)}) begin
      bad++;
      $display("FAIL rmid_grant: got %h expected %h", {rom_bus.req, rom_bus.addr}, {1'b1, AW'('h010)});
    end
    next_cycle();
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if ({rom_bus.req, i_bus.resp, d_bus.resp, i_bus.fault, d_bus.fault} !== 5'b0) begin
      bad++;
      $display("FAIL rmid_in_reset: got %b expected 00000",
               {rom_bus.req, i_bus.resp, d_bus.resp, i_bus.fault, d_bus.fault});
    end
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({rom_bus.req, i_bus.resp, d_bus.resp} !== 3'b0) begin
      bad++;
      $display("FAIL rmid_released: got %b expected 000", {rom_bus.req, i_bus.resp, d_bus.resp});
    end
    next_cycle();
    drive_port(0, 1, 'h000, 0, BUS_ACC_4B, '0);
    drive_port(1, 1, 'h008, 0, BUS_ACC_4B, '0);
    @(negedge clk);
    total++;
    if ({rom_bus.req, rom_bus.addr} !== {1'b1, AW'('h000)}) begin
      bad++;
      $display("FAIL rmid_tie_to_i: got %h expected %h", {rom_bus.req, rom_bus.addr}, {1'b1, AW'('h000)});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp, i_bus.rdata} !== {2'b10, mem[0]}) begin
      bad++;
      $display("FAIL rmid_i_resp: got %h expected %h", {i_bus.resp, d_bus.resp, i_bus.rdata}, {2'b10, mem[0]});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({i_bus.resp, d_bus.resp, d_bus.rdata} !== {2'b01, mem[2]}) begin
      bad++;
      $display("FAIL rmid_d_resp: got %h expected %h", {i_bus.resp, d_bus.resp, d_bus.rdata}, {2'b01, mem[2]});
    end
    next_cycle();
  endtask

  // Drives legal traffic (one outstanding per port) and checks every cycle against the model.
  task automatic run_traffic(input int cycles, input int i_rate, input int d_rate,
                             input int d_once, input bit clean);
    int            win, rate;
    bit            ef, go;
    logic [31:0]   tmp;
    logic [AW-1:0] a;
    logic [1:0]    exp_f;
    bus_word_t     got;
    for (int p = 0; p < 2; p++) begin
      issued[p] = 0; done[p] = 0;
    end
    d_req_cyc = -1; d_done_cyc = -1;
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < 2; p++) begin
        rate = (p == 0) ? i_rate : d_rate;
        go = !outst[p] && (c < cycles - 4) &&
             ((p == 1 && c == d_once) || ($urandom_range(99) < rate));
        if (go) begin
          tmp = $urandom;
          a = tmp[AW-1:0];
          if (clean || $urandom_range(3) != 0) a[1:0] = 2'b00;
          m_addr[p] = a;
          m_w[p]    = !clean && ($urandom_range(9) == 0);
          m_acc[p]  = clean ? BUS_ACC_4B : bus_acc_t'($urandom_range(2));
          m_wd[p]   = $urandom;
          mv[p] = 1; outst[p] = 1; issued[p]++;
          if (p == 1) d_req_cyc = c;
          drive_port(p, 1, m_addr[p], m_w[p], m_acc[p], m_wd[p]);
        end else begin
          drive_port(p, 0, '0, 0, '0, '0);
        end
      end
      win = -1;
      if (mv[0] && mv[1]) win = (mlast == 1) ? 0 : 1;
      else if (mv[0]) win = 0;
      else if (mv[1]) win = 1;
      ef = (win >= 0) && (m_w[win] || misal(m_addr[win], m_acc[win]));
      @(negedge clk);
      total++;
      if (rom_bus.req !== (win >= 0)) begin
        bad++;
        $display("FAIL traffic_req c=%0d: got %b expected %b", c, rom_bus.req, (win >= 0));
      end
      if (win >= 0) begin
        total++;
        if ({rom_bus.addr, rom_bus.w_rb, rom_bus.acc, rom_bus.wdata} !==
            {m_addr[win], m_w[win], m_acc[win], m_wd[win]}) begin
          bad++;
          $display("FAIL traffic_fields c=%0d: got %h expected %h", c,
                   {rom_bus.addr, rom_bus.w_rb, rom_bus.acc, rom_bus.wdata},
                   {m_addr[win], m_w[win], m_acc[win], m_wd[win]});
        end
      end
      exp_f = {(win == 0) && ef, (win == 1) && ef};
      total++;
      if ({i_bus.fault, d_bus.fault} !== exp_f) begin
        bad++;
        $display("FAIL traffic_fault c=%0d: got %b expected %b", c, {i_bus.fault, d_bus.fault}, exp_f);
      end
      total++;
      if ({i_bus.resp, d_bus.resp} !== {presp == 0, presp == 1}) begin
        bad++;
        $display("FAIL traffic_resp c=%0d: got %b expected %b", c, {i_bus.resp, d_bus.resp},
                 {presp == 0, presp == 1});
      end
      if (presp >= 0) begin
        got = (presp == 0) ? i_bus.rdata : d_bus.rdata;
        total++;
        if (got !== prdata) begin
          bad++;
          $display("FAIL traffic_rdata c=%0d: got %h expected %h", c, got, prdata);
        end
      end
      if (i_bus.resp || i_bus.fault) done[0]++;
      if (d_bus.resp || d_bus.fault) begin
        done[1]++;
        if (d_done_cyc < 0) d_done_cyc = c;
      end
      if (presp >= 0) outst[presp] = 0;
      presp = -1;
      if (win >= 0) begin
        mv[win] = 0;
        mlast = win;
        if (ef) outst[win] = 0;
        else begin
          presp  = win;
          prdata = mem[m_addr[win][AW-1:2]];
        end
      end
      @(posedge clk);
      #1;
    end
    drive_port(0, 0, '0, 0, '0, '0);
    drive_port(1, 0, '0, 0, '0, '0);
  endtask

  task automatic test_stream();
    do_reset();
    run_traffic(30, 100, 0, 4, 1);
    total++;
    if (done[0] !== issued[0]) begin
      bad++;
      $display("FAIL stream_i_lost: got %0d completions expected %0d", done[0], issued[0]);
    end
    total++;
    if (d_done_cyc < 0 || d_req_cyc < 0 || d_done_cyc - d_req_cyc > 2) begin
      bad++;
      $display("FAIL stream_d_latency: got req=%0d resp=%0d required resp within req+2", d_req_cyc, d_done_cyc);
    end
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(400, 45, 45, -1, 0);
    total++;
    if ({done[0], done[1]} !== {issued[0], issued[1]}) begin
      bad++;
      $display("FAIL random_completions: got %0d/%0d expected %0d/%0d", done[0], done[1], issued[0], issued[1]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    spurious = 1'b0;
    for (int k = 0; k < ROM_SIZE / 4; k++) mem[k] = $urandom;
    mem[4] = 32'hDEADBEEF;
    drive_port(0, 0, '0, 0, '0, '0);
    drive_port(1, 0, '0, 0, '0, '0);
    model_reset();
    test_reset();
    test_uncontended();
    test_contended();
    test_stream();
    test_write_fault();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter sharing one `rom_controller` between the instruction-fetch bus (port I) and the data bus (port D). Each upstream port speaks the standard femto bus protocol (addr/w_rb/acc/wdata/req in, rdata/resp/fault out). The block buffers a losing request for one cycle, grants round-robin, and routes the downstream resp/fault back to the owning port. It sits between the core's two bus masters and the ROM controller. Throughput is one access per cycle, and added latency is 0 cycles uncontended and at most 1 cycle contended.

## Interface
Parameters:
- AW, default $clog2(`ROM_SIZE): ROM byte-address width.

Ports (x ∈ {i, d}):
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- x_addr  in  AW  request byte address.
- x_w_rb  in  1  1 = write, 0 = read.
- x_acc  in  `BUS_ACC_WIDTH  access size (`BUS_ACC_1B/2B/4B).
- x_wdata  in  `BUS_WIDTH  write data, forwarded unmodified.
- x_req  in  1  single-cycle request pulse.
- x_rdata  out  `BUS_WIDTH  read data, valid when x_resp.
- x_resp  out  1  completion pulse.
- x_fault  out  1  rejection pulse; this request never gets a resp.
- rom_addr, rom_w_rb, rom_acc, rom_wdata, rom_req  out  downstream request, same widths as above.
- rom_rdata  in  `BUS_WIDTH; rom_resp  in  1; rom_fault  in  1: downstream completion and rejection.

## Operation
- Requester contract: after a req, issue no further req on that port until resp or fault. A req arriving on a port whose pending buffer is valid is dropped silently, with no resp and no fault.
- Per-port candidate: pending buffer if valid, else the live x_req with its live fields.
- Grant, combinational each cycle:
  - One candidate: it wins.
  - Two candidates: the port not equal to last_grant wins.
- A granted candidate drives rom_* in the same cycle, and last_grant takes that port. rom_req = rstn & (grant_i | grant_d). rom_* fields are 0 when no grant.
- A losing live request is captured into its port's pending buffer (addr, w_rb, acc, wdata). The buffer clears in the cycle its entry is granted.
- Fault routing: x_fault = rom_fault & grant_x, in the same cycle as rom_req (rom_fault is combinational).
- Ownership register owner_v/owner_id is loaded at each grant cycle: owner_v = rom_req & ~rom_fault, owner_id = granted port. It clears when no grant occurs.
- Response routing: x_resp = rom_resp & owner_v & (owner_id == x). Both x_rdata outputs are driven by rom_rdata. Upstream must qualify rdata with resp.
- Starvation bound: a pending entry always wins the next cycle, because last_grant points to the other port.

## Timing
- Reset: pending buffers invalid, owner_v = 0, last_grant = D (so I wins the first tie).
  - All of rom_req, x_resp, x_fault are 0 while rstn is low.
  - rom_req stays 0 in the reset cycle, even with x_req high.
- Uncontended: x_req in cycle N → rom_req in N → x_resp/x_rdata in N+1.
- Contended, both live in N, last_grant = D:
  - I goes downstream in N; I resp in N+1.
  - D is pending in N and goes downstream in N+1; D resp in N+2.
- Back-to-back: one grant per cycle. The owner register pipelines with the 1-cycle ROM latency.
- Fault: x_fault in the request's grant cycle, never later than N+1.
- Reset mid-operation: in-flight and pending requests are discarded, and no resp is emitted after reset is released.

## Structure
- femto.vh additions:
  - `ROM_ARB_PORT_I = 1'b0
  - `ROM_ARB_PORT_D = 1'b1
- Bus width and acc macros are reused unchanged.
- Sub-module rom_arb_pending: single-entry request buffer (valid + fields, capture/clear, sync reset). It is instantiated once per port.
- Top level holds the grant logic, last_grant, the owner register and the output muxing.

## Test plan
- Uncontended I read, addr 0x010, acc 4B, ROM word 0xDEADBEEF → rom_req the same cycle; i_resp=1 and i_rdata=0xDEADBEEF next cycle; d_resp stays 0.
- Simultaneous I (0x000) and D (0x004) right after reset → I granted in N, D in N+1. i_resp in N+1, d_resp in N+2, each with its own word.
- I requests every cycle it may, D requests once during that stream → D is granted within 1 cycle of its req, and no I request is lost.
- D write (w_rb=1) → d_fault in the grant cycle; no d_resp; owner_v stays 0; the next I request completes normally.
- D misaligned access (addr 0x003, acc 2B) while I is pending → d_fault routed to D only; I completes on schedule.
- rstn low for one cycle between a grant and its resp → no x_resp after release; pending is cleared; the first post-reset tie goes to I.
